// File: rtl/comb_lock_pkg.sv
// Shared state encoding and keypad constants for the combination-lock controller.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ERROR   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_OPEN    = 3'd4,
    ST_PROGRAM = 3'd5
  } state_t;

  localparam logic [4:0] KEY_CLEAR = 5'h00;
  localparam int         KEY_DIGIT = 4;

  // Thermometer code of min(n,4): bit i lit when at least i+1 digits are entered.
  function automatic logic [3:0] therm4(input int n);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      t[i] = (n > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module lock_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/comb_lock_ctrl.sv
// Combination-lock controller: keypad digit buffer, code compare, failed-attempt
// lockout, switch-driven reprogramming and registered display/indicator outputs.
module comb_lock_ctrl
  import comb_lock_pkg::*;
#(
  parameter int                    CODE_LEN     = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1111,
  parameter int                    MAX_TRIES    = 3,
  parameter int                    ERR_CYC      = 8,
  parameter int                    LOCK_CYC     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        newKey,
  input  logic [4:0]  keyCode,
  input  logic        switch,
  output logic        eLED,
  output logic        unlock,
  output logic [3:0]  radixVal,
  output logic [15:0] dispVal,
  output logic        lockedOut
);

  localparam int BUF_W   = CODE_LEN * 4;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAILS_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W   = $clog2(LOCK_CYC + 1);

  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(CODE_LEN);
  localparam logic [FAILS_W-1:0] FAILS_MAX = FAILS_W'(MAX_TRIES);

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d, buf_key;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_key;
  logic [BUF_W-1:0]     code_q, code_d;
  logic [FAILS_W-1:0]   fails_q, fails_d;
  logic                 sw_prev_q;
  logic                 eled_q, eled_d;
  logic                 unlock_q, unlock_d;
  logic                 locked_q, locked_d;
  logic [3:0]           radix_q, radix_d;
  logic [15:0]          disp_q, disp_d;
  logic [15:0]          buf_lo16;
  logic                 tmr_load, tmr_done;
  logic [TMR_W-1:0]     tmr_value;
  logic                 key_digit, key_clear, sw_rise;

  assign key_digit = newKey && keyCode[KEY_DIGIT];
  assign key_clear = newKey && (keyCode == KEY_CLEAR);
  assign sw_rise   = switch && !sw_prev_q;

  lock_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk  (clock),
    .rst_n(reset),
    .load (tmr_load),
    .value(tmr_value),
    .done (tmr_done)
  );

  // Buffer/count update for a key accepted in ENTRY or PROGRAM.
  always_comb begin
    buf_key = buf_q;
    cnt_key = cnt_q;
    if (key_clear) begin
      buf_key = '0;
      cnt_key = '0;
    end else if (key_digit && (cnt_q != CNT_FULL)) begin
      buf_key = (buf_q << 4) | BUF_W'(keyCode[3:0]);
      cnt_key = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    fails_d   = fails_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_ENTRY: begin
        if (cnt_q == CNT_FULL) begin
          state_d = ST_CHECK;
        end else begin
          buf_d = buf_key;
          cnt_d = cnt_key;
        end
      end
      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          state_d = ST_OPEN;
          fails_d = '0;
        end else begin
          fails_d  = (fails_q == FAILS_MAX) ? FAILS_MAX : fails_q + 1'b1;
          tmr_load = 1'b1;
          if (fails_d == FAILS_MAX) begin
            state_d   = ST_LOCKOUT;
            tmr_value = TMR_W'(LOCK_CYC);
          end else begin
            state_d   = ST_ERROR;
            tmr_value = TMR_W'(ERR_CYC);
          end
        end
      end
      ST_ERROR: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
          fails_d = '0;
        end
      end
      ST_OPEN: begin
        if (key_clear) begin
          state_d = ST_ENTRY;
        end else if (!switch) begin
          state_d = ST_PROGRAM;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_PROGRAM: begin
        if (sw_rise) begin
          buf_d = '0;
          cnt_d = '0;
          if (cnt_q == CNT_FULL) begin
            code_d  = buf_q;
            state_d = ST_ENTRY;
          end else begin
            state_d   = ST_ERROR;
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(ERR_CYC);
          end
        end else begin
          buf_d = buf_key;
          cnt_d = cnt_key;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  if (BUF_W >= 16) begin : g_disp_wide
    assign buf_lo16 = buf_d[15:0];
  end else begin : g_disp_narrow
    assign buf_lo16 = {{(16 - BUF_W){1'b0}}, buf_d};
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    eled_d   = (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
    unlock_d = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
    locked_d = (state_d == ST_LOCKOUT);
    disp_d   = (cnt_d == '0) ? 16'h0000 : buf_lo16;
    case (state_d)
      ST_OPEN:    radix_d = 4'b1111;
      ST_PROGRAM: radix_d = ~therm4(int'(cnt_d));
      default:    radix_d = therm4(int'(cnt_d));
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ENTRY;
      buf_q     <= '0;
      cnt_q     <= '0;
      code_q    <= DEFAULT_CODE;
      fails_q   <= '0;
      sw_prev_q <= 1'b1;
      eled_q    <= 1'b0;
      unlock_q  <= 1'b0;
      locked_q  <= 1'b0;
      radix_q   <= 4'b0000;
      disp_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      fails_q   <= fails_d;
      sw_prev_q <= switch;
      eled_q    <= eled_d;
      unlock_q  <= unlock_d;
      locked_q  <= locked_d;
      radix_q   <= radix_d;
      disp_q    <= disp_d;
    end
  end

  assign eLED      = eled_q;
  assign unlock    = unlock_q;
  assign lockedOut = locked_q;
  assign radixVal  = radix_q;
  assign dispVal   = disp_q;

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Directed bench for comb_lock_ctrl with default parameters (code 1111).
module tb_comb_lock_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        newKey;
  logic [4:0]  keyCode;
  logic        switch;
  logic        eLED;
  logic        unlock;
  logic [3:0]  radixVal;
  logic [15:0] dispVal;
  logic        lockedOut;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  comb_lock_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .newKey   (newKey),
    .keyCode  (keyCode),
    .switch   (switch),
    .eLED     (eLED),
    .unlock   (unlock),
    .radixVal (radixVal),
    .dispVal  (dispVal),
    .lockedOut(lockedOut)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [4:0] k);
    newKey  = 1'b1;
    keyCode = k;
    @(negedge clock);
    newKey  = 1'b0;
    keyCode = 5'h00;
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press({1'b1, a});
    press({1'b1, b});
    press({1'b1, c});
    press({1'b1, d});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_unlock"}, 16'(unlock), 16'h0);
    chk({tag, "_eled"}, 16'(eLED), 16'h0);
    chk({tag, "_locked"}, 16'(lockedOut), 16'h0);
    chk({tag, "_radix"}, 16'(radixVal), 16'h0);
    chk({tag, "_disp"}, dispVal, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    newKey  = 1'b0;
    keyCode = 5'h00;
    switch  = 1'b1;
    step(2);
    chk_all_zero("reset");
    reset = 1'b1;
    step(1);

    // Correct code opens two cycles after the last key
    code4(4'h1, 4'h1, 4'h1, 4'h1);
    chk("t1_disp", dispVal, 16'h1111);
    chk("t1_radix", 16'(radixVal), 16'hF);
    chk("t1_unlock_early", 16'(unlock), 16'h0);
    step(1);
    chk("t1_unlock_check", 16'(unlock), 16'h0);
    step(1);
    chk("t1_unlock", 16'(unlock), 16'h1);
    chk("t1_open_radix", 16'(radixVal), 16'hF);
    chk("t1_open_disp", dispVal, 16'h0);
    press(5'h00);
    chk("t1_relock", 16'(unlock), 16'h0);
    chk("t1_relock_radix", 16'(radixVal), 16'h0);

    // Wrong code: ERROR for 8 cycles, keys ignored meanwhile
    code4(4'h1, 4'h1, 4'h1, 4'h3);
    chk("t2_disp", dispVal, 16'h1113);
    step(2);
    chk("t2_eled", 16'(eLED), 16'h1);
    chk("t2_disp_cleared", dispVal, 16'h0);
    chk("t2_unlock", 16'(unlock), 16'h0);
    press(5'h15);
    chk("t2_key_ignored", dispVal, 16'h0);
    step(6);
    chk("t2_eled_last", 16'(eLED), 16'h1);
    step(1);
    chk("t2_eled_off", 16'(eLED), 16'h0);

    // Second and third consecutive failures -> lockout for 64 cycles
    code4(4'h1, 4'h1, 4'h1, 4'h3);
    step(2);
    chk("t3_err2_eled", 16'(eLED), 16'h1);
    chk("t3_err2_locked", 16'(lockedOut), 16'h0);
    step(8);
    chk("t3_err2_done", 16'(eLED), 16'h0);
    code4(4'h1, 4'h1, 4'h1, 4'h3);
    step(2);
    chk("t3_locked", 16'(lockedOut), 16'h1);
    chk("t3_lock_eled", 16'(eLED), 16'h1);
    press(5'h11);
    chk("t3_key_ignored", dispVal, 16'h0);
    step(62);
    chk("t3_locked_last", 16'(lockedOut), 16'h1);
    step(1);
    chk("t3_lock_over", 16'(lockedOut), 16'h0);
    chk("t3_lock_eled_off", 16'(eLED), 16'h0);
    code4(4'h1, 4'h1, 4'h1, 4'h1);
    step(2);
    chk("t3_unlock_after", 16'(unlock), 16'h1);

    // Reprogram to 2468
    switch = 1'b0;
    step(1);
    chk("t4_prog_unlock", 16'(unlock), 16'h1);
    chk("t4_prog_radix0", 16'(radixVal), 16'hF);
    press(5'h12);
    press(5'h14);
    chk("t4_prog_radix2", 16'(radixVal), 16'hC);
    chk("t4_prog_disp2", dispVal, 16'h0024);
    press(5'h16);
    press(5'h18);
    chk("t4_prog_disp4", dispVal, 16'h2468);
    chk("t4_prog_radix4", 16'(radixVal), 16'h0);
    switch = 1'b1;
    step(1);
    chk("t4_commit_unlock", 16'(unlock), 16'h0);
    chk("t4_commit_eled", 16'(eLED), 16'h0);
    chk("t4_commit_disp", dispVal, 16'h0);
    code4(4'h1, 4'h1, 4'h1, 4'h1);
    step(2);
    chk("t4_old_rejected", 16'(eLED), 16'h1);
    chk("t4_old_unlock", 16'(unlock), 16'h0);
    step(8);
    code4(4'h2, 4'h4, 4'h6, 4'h8);
    step(2);
    chk("t4_new_accepted", 16'(unlock), 16'h1);

    // Asynchronous reset while programming restores code 1111
    switch = 1'b0;
    step(1);
    press(5'h13);
    chk("t6_prog_disp", dispVal, 16'h0003);
    chk("t6_prog_radix", 16'(radixVal), 16'hE);
    #1 reset = 1'b0;
    #1;
    chk_all_zero("t6_async_prog");
    switch = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    step(1);
    code4(4'h1, 4'h1, 4'h1, 4'h1);
    step(2);
    chk("t6_code_restored", 16'(unlock), 16'h1);

    // Short program entry -> ERROR, code unchanged
    switch = 1'b0;
    step(1);
    press(5'h15);
    press(5'h15);
    switch = 1'b1;
    step(1);
    chk("t5_short_eled", 16'(eLED), 16'h1);
    chk("t5_short_unlock", 16'(unlock), 16'h0);
    step(8);
    chk("t5_short_done", 16'(eLED), 16'h0);
    code4(4'h1, 4'h1, 4'h1, 4'h1);
    step(2);
    chk("t5_code_kept", 16'(unlock), 16'h1);
    press(5'h00);
    press(5'h11);
    press(5'h12);
    chk("t5_partial_disp", dispVal, 16'h0012);
    chk("t5_partial_radix", 16'(radixVal), 16'h3);
    press(5'h00);
    chk("t5_clear_disp", dispVal, 16'h0);
    chk("t5_clear_radix", 16'(radixVal), 16'h0);

    // Asynchronous reset mid-entry
    press(5'h11);
    press(5'h12);
    chk("t6_entry_disp", dispVal, 16'h0012);
    #1 reset = 1'b0;
    #1;
    chk_all_zero("t6_async_entry");
    @(negedge clock);
    reset = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
